iterative_mdlu: RTL and testbench

Multi-cycle multiply/divide responder for the MIPS datapath. The execute stage issues a MULT/MULTU/DIV/DIVU request through a start/busy/done handshake. This block computes the 64-bit HI/LO result iteratively, one bit per cycle, and presents it for the HI/LO register write. It replaces single-cycle combinational mult/div so the 32-bit multiplier and divider arrays do not sit on the critical path.

---
 rtl/iterative_mdlu.sv | 129 ++++++++++++
 tb/tb_iterative_mdlu.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/iterative_mdlu.sv
// Iterative 32x32 multiply / divide unit producing HI/LO, one bit per cycle.
// Signed ops run on magnitudes; signs are restored in a final fix-up cycle.
module iterative_mdlu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        divByZero
);

  typedef enum logic [2:0] {StIdle, StPrep, StRun, StFix, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q;
  logic        neg_q, rneg_q;

  logic        is_div, is_signed;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum, div_trial;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StPrep;
      StPrep:  state_d = (is_div && b_q == '0) ? StDone : StRun;
      StRun:   if (cnt_q == 6'd31) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  always_comb begin
    abs_a     = (is_signed && a_q[31]) ? -a_q : a_q;
    abs_b     = (is_signed && b_q[31]) ? -b_q : b_q;
    mul_sum   = {1'b0, acc_q[63:32]} + (b_q[0] ? {1'b0, a_q} : 33'd0);
    // Shifted partial remainder is 33 bits; bit 32 of the difference is the borrow.
    div_trial = acc_q[63:31] - {1'b0, b_q};
    prod      = neg_q ? -acc_q : acc_q;
    quo       = neg_q ? -acc_q[31:0] : acc_q[31:0];
    rem       = rneg_q ? -acc_q[63:32] : acc_q[63:32];
  end

  // acc_q holds the product for multiply and {remainder, quotient} for divide.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      divByZero <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q      <= op;
            a_q       <= operandA;
            b_q       <= operandB;
            divByZero <= 1'b0;
          end
        end
        StPrep: begin
          neg_q  <= is_signed & (a_q[31] ^ b_q[31]);
          rneg_q <= is_signed & a_q[31];
          cnt_q  <= '0;
          if (is_div && b_q == '0) begin
            lo        <= 32'hFFFF_FFFF;
            hi        <= a_q;
            divByZero <= 1'b1;
          end else begin
            a_q   <= abs_a;
            b_q   <= abs_b;
            acc_q <= is_div ? {32'd0, abs_a} : 64'd0;
          end
        end
        StRun: begin
          cnt_q <= cnt_q + 6'd1;
          if (is_div) begin
            if (!div_trial[32]) acc_q <= {div_trial[31:0], acc_q[30:0], 1'b1};
            else                acc_q <= {acc_q[62:0], 1'b0};
          end else begin
            acc_q <= {mul_sum, acc_q[31:1]};
            b_q   <= b_q >> 1;
          end
        end
        StFix: begin
          if (is_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            hi <= prod[63:32];
            lo <= prod[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_mdlu.sv
// Bench for iterative_mdlu: per-cycle comparison against a cycle-count/arithmetic model,
// directed literal cases and randomized operations.
module tb_iterative_mdlu;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] operandA, operandB;
  logic        busy, done, divByZero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  iterative_mdlu dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operandA  (operandA),
    .operandB  (operandB),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .divByZero (divByZero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l, output logic d);
    longint      sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    d  = 1'b0;
    h  = '0;
    l  = '0;
    case (o)
      2'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
      2'd2: begin
        if (b == '0) begin d = 1'b1; h = a; l = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
      end
      default: begin
        if (b == '0) begin d = 1'b1; h = a; l = 32'hFFFF_FFFF; end
        else begin h = a % b; l = a / b; end
      end
    endcase
  endfunction

  // Model: cycles remaining until idle; done when one cycle remains.
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_dbz = 1'b0, p_dbz = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
      m_dbz  = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        model_op(op, operandA, operandB, p_hi, p_lo, p_dbz);
        m_dbz  = 1'b0;
        m_left = p_dbz ? 2 : 35;
      end
    end else begin
      m_left--;
      if (m_left == 1) begin
        m_hi  = p_hi;
        m_lo  = p_lo;
        m_dbz = p_dbz;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_left > 0);
    chk("done", done, m_left == 1);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("divByZero", divByZero, m_dbz);
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy !== 1'b0; i++) @(negedge clk);
    chk("idle_wait", busy, 0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #2;
    start = 1'b1; op = o; operandA = a; operandB = b;
    @(posedge clk);
    #2;
    start = 1'b0; op = 2'($urandom); operandA = $urandom; operandB = $urandom;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit lit, input logic [31:0] eh, input logic [31:0] el,
                        input logic ed, input int elat);
    int k;
    k = 999;
    wait_idle();
    issue(o, a, b);
    @(negedge clk);
    chk("flag_clear", divByZero, 0);
    for (int i = 0; i < 60; i++) begin
      if (i > 0) @(negedge clk);
      if (done === 1'b1) begin k = i; break; end
    end
    chk("latency", k, elat);
    if (lit) begin
      chk("lit_hi", hi, eh);
      chk("lit_lo", lo, el);
      chk("lit_dbz", divByZero, ed);
    end
    @(negedge clk);
    chk("busy_fall", busy, 0);
  endtask

  initial begin
    int dcount, dk;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = '0; operandA = '0; operandB = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dbz", divByZero, 0);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 0, 34);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 34);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 32'h8000_0000, 0, 34);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 34);
    run_op(2'd3, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0, 34);
    run_op(2'd3, 32'd100, 32'd0, 1, 32'd100, 32'hFFFF_FFFF, 1, 1);
    run_op(2'd1, 32'd3, 32'd4, 1, 32'd0, 32'd12, 0, 34);

    // Request while busy must be dropped.
    wait_idle();
    issue(2'd1, 32'd5, 32'd6);
    repeat (9) @(posedge clk);
    #2 start = 1'b1; op = 2'd3; operandA = 32'd9; operandB = 32'd3;
    @(posedge clk);
    #2 start = 1'b0;
    dcount = 0; dk = -1;
    for (int k = 10; k <= 45; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin dcount++; dk = k; end
    end
    chk("drop_dcount", dcount, 1);
    chk("drop_latency", dk, 34);
    chk("drop_hi", hi, 0);
    chk("drop_lo", lo, 30);

    // Reset mid-operation discards it.
    wait_idle();
    issue(2'd1, 32'd5, 32'd6);
    repeat (19) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_hi", hi, 0);
    chk("rst_mid_lo", lo, 0);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("rst_no_done", dcount, 0);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'd0, 32'd1, 0, 34);

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'd0;
        2:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'd1;
        3:       rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, 0, '0, '0, 1'b0, (ro[1] && rb == '0) ? 1 : 34);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
